// File: rtl/vga_pkg.sv
// Shared VGA timing definitions: per-axis region states, default XGA
// (1024x768) timing constants and the test-pattern colour bar table.
package vga_pkg;

  typedef enum logic [1:0] {
    ACTIVE = 2'd0,
    FRONT  = 2'd1,
    SYNC   = 2'd2,
    BACK   = 2'd3
  } axis_state_t;

  localparam int CNT_W     = 11;
  localparam int MAX_TOTAL = 2048;

  localparam int XGA_H_ACTIVE = 1024;
  localparam int XGA_H_FP     = 24;
  localparam int XGA_H_SYNC   = 136;
  localparam int XGA_H_BP     = 160;

  localparam int XGA_V_ACTIVE = 768;
  localparam int XGA_V_FP     = 3;
  localparam int XGA_V_SYNC   = 6;
  localparam int XGA_V_BP     = 29;

  // Bars left to right; element 0 is the leftmost bar.
  localparam logic [0:7][23:0] BAR_COLOURS = {
    24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
    24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000
  };

  function automatic logic [23:0] bar_colour(input logic [2:0] idx);
    return BAR_COLOURS[idx];
  endfunction

endpackage

// File: rtl/vga_axis_counter.sv
// One timing axis: a wrapping position counter plus the region FSM
// ACTIVE -> FRONT -> SYNC -> BACK. The state always describes the
// current count; 'last' flags the final count so the next axis can chain.
module vga_axis_counter
  import vga_pkg::*;
#(
  parameter int ACT_LEN  = XGA_H_ACTIVE,
  parameter int FP_LEN   = XGA_H_FP,
  parameter int SYNC_LEN = XGA_H_SYNC,
  parameter int BP_LEN   = XGA_H_BP
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              en,
  output logic [CNT_W-1:0]  cnt,
  output axis_state_t       state,
  output logic              last
);

  localparam int TOTAL = ACT_LEN + FP_LEN + SYNC_LEN + BP_LEN;

  localparam logic [CNT_W-1:0] ACT_END  = CNT_W'(ACT_LEN - 1);
  localparam logic [CNT_W-1:0] FP_END   = CNT_W'(ACT_LEN + FP_LEN - 1);
  localparam logic [CNT_W-1:0] SYNC_END = CNT_W'(ACT_LEN + FP_LEN + SYNC_LEN - 1);
  localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(TOTAL - 1);

  logic [CNT_W-1:0] cnt_next;
  axis_state_t      state_next;

  assign last = (cnt == LAST_CNT);

  // Counter and region state registers
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      cnt   <= '0;
      state <= ACTIVE;
    end else begin
      cnt   <= cnt_next;
      state <= state_next;
    end
  end

  // Advance the count and leave a region on its final count
  always_comb begin
    cnt_next   = cnt;
    state_next = state;
    if (en) begin
      cnt_next = last ? '0 : cnt + CNT_W'(1);
      case (state)
        ACTIVE:  if (cnt == ACT_END)  state_next = FRONT;
        FRONT:   if (cnt == FP_END)   state_next = SYNC;
        SYNC:    if (cnt == SYNC_END) state_next = BACK;
        BACK:    if (last)            state_next = ACTIVE;
        default: state_next = ACTIVE;
      endcase
    end
  end

endmodule

// File: rtl/vga_timing_gen.sv
// VGA timing generator: horizontal and vertical axis counters with region
// FSMs, decoded into registered, mutually aligned sync/blank/frame_start
// and pixel outputs. Define VGA_TEST_PATTERN_EN to build the 8-bar colour
// test pattern; otherwise pixel is constant black.
module vga_timing_gen
  import vga_pkg::*;
#(
  parameter int   H_ACTIVE = XGA_H_ACTIVE,
  parameter int   H_FP     = XGA_H_FP,
  parameter int   H_SYNC   = XGA_H_SYNC,
  parameter int   H_BP     = XGA_H_BP,
  parameter int   V_ACTIVE = XGA_V_ACTIVE,
  parameter int   V_FP     = XGA_V_FP,
  parameter int   V_SYNC   = XGA_V_SYNC,
  parameter int   V_BP     = XGA_V_BP,
  parameter logic HS_POL   = 1'b0,
  parameter logic VS_POL   = 1'b0
) (
  input  logic              clk,
  input  logic              reset,
  input  logic              pix_en,
  output logic [CNT_W-1:0]  hc,
  output logic [CNT_W-1:0]  vc,
  output logic              hsync,
  output logic              vsync,
  output logic              blank,
  output logic              frame_start,
  output logic [23:0]       pixel
);

  localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
  localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

  if (H_TOTAL > MAX_TOTAL) begin : g_h_total_err
    $error("vga_timing_gen: H_TOTAL exceeds the 11-bit counter range");
  end
  if (V_TOTAL > MAX_TOTAL) begin : g_v_total_err
    $error("vga_timing_gen: V_TOTAL exceeds the 11-bit counter range");
  end
  if (H_ACTIVE < 1 || H_FP < 1 || H_SYNC < 1 || H_BP < 1 ||
      V_ACTIVE < 1 || V_FP < 1 || V_SYNC < 1 || V_BP < 1) begin : g_region_err
    $error("vga_timing_gen: every timing region must be at least one count wide");
  end

  logic [CNT_W-1:0] h_cnt;
  logic [CNT_W-1:0] v_cnt;
  axis_state_t      h_state;
  axis_state_t      v_state;
  logic             h_last;
  logic             v_last;
  logic             v_en;
  logic             in_active;

  // The line counter steps on the pixel strobe where the pixel counter wraps.
  assign v_en      = pix_en & h_last;
  assign in_active = (h_state == ACTIVE) && (v_state == ACTIVE);

  vga_axis_counter #(
    .ACT_LEN  (H_ACTIVE),
    .FP_LEN   (H_FP),
    .SYNC_LEN (H_SYNC),
    .BP_LEN   (H_BP)
  ) u_h_axis (
    .clk   (clk),
    .reset (reset),
    .en    (pix_en),
    .cnt   (h_cnt),
    .state (h_state),
    .last  (h_last)
  );

  vga_axis_counter #(
    .ACT_LEN  (V_ACTIVE),
    .FP_LEN   (V_FP),
    .SYNC_LEN (V_SYNC),
    .BP_LEN   (V_BP)
  ) u_v_axis (
    .clk   (clk),
    .reset (reset),
    .en    (v_en),
    .cnt   (v_cnt),
    .state (v_state),
    .last  (v_last)
  );

  // Present the counters' current position on each pixel strobe; the
  // counters themselves already point at the next position.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      hc          <= '0;
      vc          <= '0;
      hsync       <= ~HS_POL;
      vsync       <= ~VS_POL;
      blank       <= 1'b0;
      frame_start <= 1'b0;
    end else begin
      frame_start <= 1'b0;
      if (pix_en) begin
        hc          <= h_cnt;
        vc          <= v_cnt;
        hsync       <= (h_state == SYNC) ? HS_POL : ~HS_POL;
        vsync       <= (v_state == SYNC) ? VS_POL : ~VS_POL;
        blank       <= ~in_active;
        frame_start <= (h_cnt == '0) && (v_cnt == '0);
      end
    end
  end

`ifdef VGA_TEST_PATTERN_EN
  localparam int               BAR_W   = (H_ACTIVE >= 8) ? (H_ACTIVE / 8) : 1;
  localparam logic [CNT_W-1:0] BAR_DIV = CNT_W'(BAR_W);

  logic [CNT_W-1:0] bar_idx;
  logic [23:0]      pixel_next;

  // Pick the bar colour for the position being presented; black when blanked.
  always_comb begin
    bar_idx    = h_cnt / BAR_DIV;
    pixel_next = 24'h000000;
    if (in_active) begin
      pixel_next = bar_colour((bar_idx > CNT_W'(7)) ? 3'd7 : bar_idx[2:0]);
    end
  end

  // Pixel register, aligned with the timing outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      pixel <= 24'h000000;
    end else if (pix_en) begin
      pixel <= pixel_next;
    end
  end
`else
  assign pixel = 24'h000000;
`endif

  logic unused_ok;
  assign unused_ok = v_last;

endmodule

// File: tb/tb_vga_timing_gen.sv
// Bench for vga_timing_gen using a reduced timing (24x13 totals) so whole
// frames fit in a short run. A reference model pushes the expected outputs
// for every clock into a queue; a monitor pops and compares after the edge.
module tb_vga_timing_gen;

  localparam int HA = 16, HF = 2, HS = 3, HB = 3;
  localparam int VA = 8,  VF = 1, VS = 2, VB = 2;
  localparam int HT = HA + HF + HS + HB;
  localparam int VT = VA + VF + VS + VB;
  localparam logic HP = 1'b0;
  localparam logic VP = 1'b0;

`ifdef VGA_TEST_PATTERN_EN
  localparam bit PAT = 1'b1;
`else
  localparam bit PAT = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        pix_en = 1'b0;
  logic [10:0] hc;
  logic [10:0] vc;
  logic        hsync;
  logic        vsync;
  logic        blank;
  logic        frame_start;
  logic [23:0] pixel;

  typedef struct packed {
    logic [10:0] hc;
    logic [10:0] vc;
    logic        hs;
    logic        vs;
    logic        blank;
    logic        fs;
    logic [23:0] px;
  } obs_t;

  obs_t exp_q[$];
  obs_t mout;
  obs_t e;
  int   mh = 0;
  int   mv = 0;
  int   total = 0;
  int   bad = 0;
  logic [23:0] bars [8] = '{24'hFFFFFF, 24'hFFFF00, 24'h00FFFF, 24'h00FF00,
                            24'hFF00FF, 24'hFF0000, 24'h0000FF, 24'h000000};

  vga_timing_gen #(
    .H_ACTIVE (HA), .H_FP (HF), .H_SYNC (HS), .H_BP (HB),
    .V_ACTIVE (VA), .V_FP (VF), .V_SYNC (VS), .V_BP (VB),
    .HS_POL   (HP), .VS_POL (VP)
  ) dut (
    .clk         (clk),
    .reset       (reset),
    .pix_en      (pix_en),
    .hc          (hc),
    .vc          (vc),
    .hsync       (hsync),
    .vsync       (vsync),
    .blank       (blank),
    .frame_start (frame_start),
    .pixel       (pixel)
  );

  always #5 clk = ~clk;

  function automatic obs_t reset_obs();
    obs_t r;
    r.hc = '0; r.vc = '0; r.hs = ~HP; r.vs = ~VP;
    r.blank = 1'b0; r.fs = 1'b0; r.px = 24'h000000;
    return r;
  endfunction

  function automatic logic [23:0] exp_pixel(input int h, input int v);
    if (PAT && h < HA && v < VA) return bars[h / (HA / 8)];
    return 24'h000000;
  endfunction

  // Reference model for one rising edge, given the inputs held across it.
  task automatic model_edge(input logic en);
    if (!reset) begin
      mh = 0; mv = 0; mout = reset_obs();
    end else begin
      mout.fs = 1'b0;
      if (en) begin
        mout.hc    = 11'(mh);
        mout.vc    = 11'(mv);
        mout.hs    = (mh >= HA + HF && mh < HA + HF + HS) ? HP : ~HP;
        mout.vs    = (mv >= VA + VF && mv < VA + VF + VS) ? VP : ~VP;
        mout.blank = !(mh < HA && mv < VA);
        mout.fs    = (mh == 0 && mv == 0);
        mout.px    = exp_pixel(mh, mv);
        mh++;
        if (mh == HT) begin
          mh = 0; mv++;
          if (mv == VT) mv = 0;
        end
      end
    end
    exp_q.push_back(mout);
  endtask

  // Drive one clock: inputs at the falling edge, return 2 time units after the rise.
  task automatic cycle(input logic en);
    @(negedge clk);
    pix_en = en;
    model_edge(en);
    @(posedge clk);
    #2;
  endtask

  // Scoreboard monitor
  always @(posedge clk) begin
    #1;
    if (exp_q.size() > 0) begin
      e = exp_q.pop_front();
      total++; if (hc !== e.hc) begin bad++; $display("FAIL sb_hc t=%0t got=%0d exp=%0d", $time, hc, e.hc); end
      total++; if (vc !== e.vc) begin bad++; $display("FAIL sb_vc t=%0t got=%0d exp=%0d", $time, vc, e.vc); end
      total++; if (hsync !== e.hs) begin bad++; $display("FAIL sb_hsync t=%0t got=%b exp=%b hc=%0d", $time, hsync, e.hs, e.hc); end
      total++; if (vsync !== e.vs) begin bad++; $display("FAIL sb_vsync t=%0t got=%b exp=%b vc=%0d", $time, vsync, e.vs, e.vc); end
      total++; if (blank !== e.blank) begin bad++; $display("FAIL sb_blank t=%0t got=%b exp=%b hc=%0d vc=%0d", $time, blank, e.blank, e.hc, e.vc); end
      total++; if (frame_start !== e.fs) begin bad++; $display("FAIL sb_frame_start t=%0t got=%b exp=%b", $time, frame_start, e.fs); end
      total++; if (pixel !== e.px) begin bad++; $display("FAIL sb_pixel t=%0t got=%h exp=%h hc=%0d vc=%0d", $time, pixel, e.px, e.hc, e.vc); end
    end
  end

  task automatic test_reset();
    #3;
    reset = 1'b0;
    pix_en = 1'b1;
    mh = 0; mv = 0; mout = reset_obs();
    #1;
    total++; if (hc !== 11'd0 || vc !== 11'd0) begin bad++; $display("FAIL reset_counters got hc=%0d vc=%0d exp 0 0", hc, vc); end
    total++; if (hsync !== ~HP || vsync !== ~VP) begin bad++; $display("FAIL reset_sync got hs=%b vs=%b exp %b %b", hsync, vsync, ~HP, ~VP); end
    total++; if (blank !== 1'b0 || frame_start !== 1'b0) begin bad++; $display("FAIL reset_blank_fs got blank=%b fs=%b exp 0 0", blank, frame_start); end
    total++; if (pixel !== 24'h000000) begin bad++; $display("FAIL reset_pixel got=%h exp=000000", pixel); end
    for (int i = 0; i < 3; i++) cycle(1'b1);
  endtask

  task automatic test_first_pixel();
    @(negedge clk);
    reset = 1'b1;
    pix_en = 1'b1;
    model_edge(1'b1);
    @(posedge clk);
    #2;
    total++; if (hc !== 11'd0 || vc !== 11'd0) begin bad++; $display("FAIL first_pos got hc=%0d vc=%0d exp 0 0", hc, vc); end
    total++; if (frame_start !== 1'b1) begin bad++; $display("FAIL first_fs got=%b exp=1", frame_start); end
    total++; if (blank !== 1'b0) begin bad++; $display("FAIL first_blank got=%b exp=0", blank); end
    cycle(1'b1);
    total++; if (hc !== 11'd1 || frame_start !== 1'b0) begin bad++; $display("FAIL second_pixel got hc=%0d fs=%b exp 1 0", hc, frame_start); end
  endtask

  task automatic test_free_run();
    int   hs_cnt = 0, vs_cnt = 0, bl_cnt = 0, fs_cnt = 0;
    int   run = 0, run_start = 0, last_fs = -1;
    logic in_run = 1'b0;
    logic prev_hs;
    prev_hs = hsync;
    for (int i = 0; i < 2 * HT * VT; i++) begin
      cycle(1'b1);
      if (hsync == HP) hs_cnt++;
      if (vsync == VP) vs_cnt++;
      if (blank) bl_cnt++;
      if (frame_start) begin
        fs_cnt++;
        if (last_fs >= 0) begin
          total++; if (i - last_fs != HT * VT) begin bad++; $display("FAIL fs_period got=%0d exp=%0d", i - last_fs, HT * VT); end
        end
        last_fs = i;
      end
      if (hsync == HP && prev_hs != HP) begin in_run = 1'b1; run = 0; run_start = int'(hc); end
      if (in_run && hsync == HP) run++;
      if (in_run && hsync != HP) begin
        in_run = 1'b0;
        total++; if (run != HS || run_start != HA + HF) begin bad++; $display("FAIL hsync_run got len=%0d start=%0d exp len=%0d start=%0d", run, run_start, HS, HA + HF); end
      end
      prev_hs = hsync;
    end
    total++; if (hs_cnt != 2 * VT * HS) begin bad++; $display("FAIL hsync_total got=%0d exp=%0d", hs_cnt, 2 * VT * HS); end
    total++; if (vs_cnt != 2 * HT * VS) begin bad++; $display("FAIL vsync_total got=%0d exp=%0d", vs_cnt, 2 * HT * VS); end
    total++; if (bl_cnt != 2 * (HT * VT - HA * VA)) begin bad++; $display("FAIL blank_total got=%0d exp=%0d", bl_cnt, 2 * (HT * VT - HA * VA)); end
    total++; if (fs_cnt != 2) begin bad++; $display("FAIL fs_count got=%0d exp=2", fs_cnt); end
  endtask

  task automatic test_pix_en_sparse();
    int   fs_cnt = 0, last_wrap = -1;
    logic prev_fs;
    logic [10:0] prev_hc;
    prev_fs = frame_start;
    prev_hc = hc;
    for (int i = 0; i < 4 * HT * VT; i++) begin
      cycle((i % 4) == 0);
      if (frame_start) fs_cnt++;
      total++; if (frame_start && prev_fs) begin bad++; $display("FAIL fs_width got two-cycle pulse at step %0d exp one cycle", i); end
      if (hc == 11'd0 && prev_hc != 11'd0) begin
        if (last_wrap >= 0) begin
          total++; if (i - last_wrap != 4 * HT) begin bad++; $display("FAIL sparse_line got=%0d clk exp=%0d", i - last_wrap, 4 * HT); end
        end
        last_wrap = i;
      end
      prev_fs = frame_start;
      prev_hc = hc;
    end
    total++; if (fs_cnt != 1) begin bad++; $display("FAIL sparse_fs_count got=%0d exp=1", fs_cnt); end
  endtask

  task automatic test_reset_mid();
    int n = 0;
    while (!(mout.hc == 11'd10 && mout.vc == 11'd5) && n < HT * VT + 4) begin
      cycle(1'b1);
      n++;
    end
    total++; if (hc !== 11'd10 || vc !== 11'd5) begin bad++; $display("FAIL mid_reach got hc=%0d vc=%0d exp 10 5", hc, vc); end
    reset = 1'b0;
    mh = 0; mv = 0; mout = reset_obs();
    #1;
    total++; if (hc !== 11'd0 || vc !== 11'd0 || blank !== 1'b0) begin bad++; $display("FAIL mid_async got hc=%0d vc=%0d blank=%b exp 0 0 0", hc, vc, blank); end
    total++; if (hsync !== ~HP || vsync !== ~VP || pixel !== 24'h0) begin bad++; $display("FAIL mid_async_out got hs=%b vs=%b px=%h", hsync, vsync, pixel); end
    cycle(1'b1);
    cycle(1'b1);
    @(negedge clk);
    reset = 1'b1;
    pix_en = 1'b1;
    model_edge(1'b1);
    @(posedge clk);
    #2;
    total++; if (hc !== 11'd0 || vc !== 11'd0 || frame_start !== 1'b1) begin bad++; $display("FAIL mid_restart got hc=%0d vc=%0d fs=%b exp 0 0 1", hc, vc, frame_start); end
  endtask

  task automatic test_pattern_line0();
    logic [23:0] want;
    for (int i = 0; i < HT; i++) begin
      if (i > 0) cycle(1'b1);
      want = 24'h000000;
      if (PAT && hc <= 11'd1)                   want = 24'hFFFFFF;
      else if (PAT && hc >= 11'd2 && hc <= 11'd3) want = 24'hFFFF00;
      else if (PAT && hc < 11'(HA))              want = bars[int'(hc) / 2];
      total++; if (vc !== 11'd0 || hc !== 11'(i)) begin bad++; $display("FAIL pat_pos got hc=%0d vc=%0d exp %0d 0", hc, vc, i); end
      total++; if (pixel !== want) begin bad++; $display("FAIL pat_pixel hc=%0d got=%h exp=%h", hc, pixel, want); end
    end
  endtask

  initial begin : watchdog
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_first_pixel();
    test_free_run();
    test_pix_en_sparse();
    test_reset_mid();
    test_pattern_line0();
    cycle(1'b0);
    total++; if (exp_q.size() != 0) begin bad++; $display("FAIL sb_drain got=%0d pending exp=0", exp_q.size()); end
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
